// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage: decodes 16-bit instructions into registered ALU
// operands and select lines, and owns the register file and carry flag writeback.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [7:0]  ex_a,
  output logic [7:0]  ex_b,
  output logic [4:0]  ex_s,
  output logic [1:0]  ex_rd,
  output logic        ex_we,
  output logic        ex_fwe,
  input  logic        wb_en,
  input  logic [1:0]  wb_rd,
  input  logic [7:0]  wb_data,
  input  logic        wb_fen,
  input  logic        wb_cout,
  output logic        halted,
  output logic        illegal
);

  logic [7:0] rf_reg [4];
  logic [7:0] rf_view [4];
  logic       c_reg;
  logic       c_view;

  logic       ex_valid_reg;
  logic [7:0] ex_a_reg, ex_b_reg;
  logic [4:0] ex_s_reg;
  logic [1:0] ex_rd_reg;
  logic       ex_we_reg, ex_fwe_reg;
  logic       halted_reg, illegal_reg;

  logic [3:0] opcode;
  logic [1:0] rd_f, rs_f;
  logic [7:0] imm;
  logic [7:0] rd_val, rs_val;

  logic [7:0] dec_a, dec_b;
  logic [4:0] dec_s;
  logic [1:0] dec_rd;
  logic       dec_we, dec_fwe, dec_halt, dec_illegal, dec_op;
  logic       accept;

  // Same-cycle writeback is visible to the operand mux before the register updates.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bypass
    assign rf_view[gi] = (wb_en && wb_rd == 2'(gi)) ? wb_data : rf_reg[gi];
  end
  assign c_view = wb_fen ? wb_cout : c_reg;

  assign opcode = in_instr[15:12];
  assign rd_f   = in_instr[11:10];
  assign rs_f   = in_instr[9:8];
  assign imm    = in_instr[7:0];
  assign rd_val = rf_view[rd_f];
  assign rs_val = rf_view[rs_f];

  assign in_ready = !halted_reg && (!ex_valid_reg || ex_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_a       = 8'h00;
    dec_b       = 8'h00;
    dec_s       = 5'b00000;
    dec_rd      = 2'd0;
    dec_we      = 1'b0;
    dec_fwe     = 1'b0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    dec_op      = 1'b1;
    case (opcode)
      4'h0: dec_op = 1'b0;
      4'h1: begin dec_a = rd_val; dec_b = rs_val; dec_s = 5'b00000; dec_fwe = 1'b1; end
      4'h2: begin dec_a = rd_val; dec_b = rs_val; dec_s = 5'b01100; dec_fwe = 1'b1; end
      4'h3: begin dec_a = rd_val; dec_b = rs_val; dec_s = 5'b00001; end
      4'h4: begin dec_a = rd_val; dec_b = 8'h00;  dec_s = 5'b10100; dec_fwe = 1'b1; end
      4'h5: begin dec_a = rd_val; dec_b = rs_val; dec_s = 5'b00011; end
      4'h6: begin dec_a = rd_val; dec_b = imm;    dec_s = 5'b00011; end
      4'h7: begin dec_a = rd_val; dec_b = imm;    dec_s = 5'b00000; dec_fwe = 1'b1; end
      4'h8: begin dec_a = rd_val; dec_b = rs_val; dec_s = {2'b00, c_view, 2'b00}; dec_fwe = 1'b1; end
      4'hF: begin dec_op = 1'b0; dec_halt = 1'b1; end
      default: begin dec_op = 1'b0; dec_illegal = 1'b1; end
    endcase
    if (dec_op) begin
      dec_we = 1'b1;
      dec_rd = rd_f;
    end
  end

  // Writeback keeps running after halt; only the front end stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf_reg[i] <= 8'h00;
      c_reg <= 1'b0;
    end else begin
      if (wb_en) rf_reg[wb_rd] <= wb_data;
      if (wb_fen) c_reg <= wb_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      ex_a_reg     <= 8'h00;
      ex_b_reg     <= 8'h00;
      ex_s_reg     <= 5'b00000;
      ex_rd_reg    <= 2'd0;
      ex_we_reg    <= 1'b0;
      ex_fwe_reg   <= 1'b0;
      halted_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      illegal_reg <= accept && dec_illegal;
      if (accept) begin
        ex_valid_reg <= 1'b1;
        ex_a_reg     <= dec_a;
        ex_b_reg     <= dec_b;
        ex_s_reg     <= dec_s;
        ex_rd_reg    <= dec_rd;
        ex_we_reg    <= dec_we;
        ex_fwe_reg   <= dec_fwe;
        if (dec_halt) halted_reg <= 1'b1;
      end else if (ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign ex_valid = ex_valid_reg;
  assign ex_a     = ex_a_reg;
  assign ex_b     = ex_b_reg;
  assign ex_s     = ex_s_reg;
  assign ex_rd    = ex_rd_reg;
  assign ex_we    = ex_we_reg;
  assign ex_fwe   = ex_fwe_reg;
  assign halted   = halted_reg;
  assign illegal  = illegal_reg;

endmodule
